curve_fit_predictor: RTL and testbench

- Downstream consumer of the row buffer in the SZ first stages.
- Takes the current sample plus the three preceding samples (q1 oldest, q3 newest) and forms the order-0, order-1 and order-2 curve-fitting predictions.
- Selects the best-fit predictor against the error bound and emits a 2-bit code: 1..3 = predictor order+1, 0 = unpredictable.
- 3-stage pipeline with valid/ready handshake; feeds the quantization/encoding stage.

---
 rtl/curve_fit_predictor.sv | 240 ++++++++++++++++++++++++
 tb/tb_curve_fit_predictor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/curve_fit_predictor.sv
// -----------------------------------------------------------------------------
// curve_fit_predictor
//
// Purpose:
//   Curve-fitting predictor of the SZ compression front end. For each incoming
//   sample it forms the order-0, order-1 and order-2 extrapolations from the
//   three preceding samples, measures how far each lands from the real
//   sample, and picks the closest one that is still inside the error bound.
//   The chosen order is reported as a 2-bit code (1..3 = order+1), or 0 when
//   no predictor is close enough. Results go to the quantization/encoding
//   stage.
//
//   Three register stages (predictions, errors, select/output) share a single
//   advance enable, so a downstream stall freezes the whole pipe and no
//   sample is lost or duplicated. With out_ready held high the block accepts
//   one sample per clock.
//
// Parameters:
//   WIDTH  sample width, signed two's complement
//   CNT_W  width of the saturating unpredictable-point counter
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset; flushes the pipe
//   in_valid      data, q1..q3 and err_bound are valid
//   in_ready      block accepts an input this cycle
//   data          current sample (signed)
//   q1, q2, q3    samples t-3, t-2, t-1 (signed); q3 is closest to data
//   err_bound     absolute error bound (unsigned)
//   out_valid     output slot holds a result
//   out_ready     downstream accepts the result
//   out_code      0 = unpredictable, 1/2/3 = order 0/1/2 chosen
//   out_data      original sample, passed through
//   out_err       |error| of chosen predictor (order-0 error when code = 0)
//   unpred_count  number of code-0 results handed downstream, saturating
// -----------------------------------------------------------------------------
module curve_fit_predictor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data,
  input  logic [WIDTH-1:0]   q1,
  input  logic [WIDTH-1:0]   q2,
  input  logic [WIDTH-1:0]   q3,
  input  logic [WIDTH-1:0]   err_bound,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_code,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH+3:0]   out_err,
  output logic [CNT_W-1:0]   unpred_count
);

  // Four guard bits: |p2| <= 7*2^(WIDTH-1) and |data - p2| <= 2^(WIDTH+2),
  // both of which fit a WIDTH+4 two's complement value without wrapping.
  localparam int EW = WIDTH + 4;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic advance;
  logic inXfer;
  logic outXfer;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign inXfer   = in_valid && in_ready;
  assign outXfer  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [EW-1:0] signExt(input logic [WIDTH-1:0] v);
    return {{4{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [EW-1:0] absVal(input logic [EW-1:0] v);
    return v[EW-1] ? (~v + EW'(1)) : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: predictions
  // ---------------------------------------------------------------------------
  logic [EW-1:0] q1X;
  logic [EW-1:0] q2X;
  logic [EW-1:0] q3X;
  logic [EW-1:0] p0_d;
  logic [EW-1:0] p1_d;
  logic [EW-1:0] p2_d;

  assign q1X = signExt(q1);
  assign q2X = signExt(q2);
  assign q3X = signExt(q3);

  // Multiplies by 2 and 3 are shift-and-add; two's complement add/sub gives
  // the signed result directly in the extended width.
  assign p0_d = q3X;
  assign p1_d = (q3X << 1) - q2X;
  assign p2_d = ((q3X << 1) + q3X) - ((q2X << 1) + q2X) + q1X;

  logic               s1Valid_q;
  logic [EW-1:0]      s1P0_q;
  logic [EW-1:0]      s1P1_q;
  logic [EW-1:0]      s1P2_q;
  logic [WIDTH-1:0]   s1Data_q;
  logic [WIDTH-1:0]   s1Bound_q;

  // ---------------------------------------------------------------------------
  // Stage 2: absolute errors
  // ---------------------------------------------------------------------------
  logic [EW-1:0] s1DataX;
  logic [EW-1:0] e0_d;
  logic [EW-1:0] e1_d;
  logic [EW-1:0] e2_d;

  assign s1DataX = signExt(s1Data_q);
  assign e0_d    = absVal(s1DataX - s1P0_q);
  assign e1_d    = absVal(s1DataX - s1P1_q);
  assign e2_d    = absVal(s1DataX - s1P2_q);

  logic               s2Valid_q;
  logic [EW-1:0]      s2E0_q;
  logic [EW-1:0]      s2E1_q;
  logic [EW-1:0]      s2E2_q;
  logic [WIDTH-1:0]   s2Data_q;
  logic [WIDTH-1:0]   s2Bound_q;

  // ---------------------------------------------------------------------------
  // Stage 3: select best predictor
  // ---------------------------------------------------------------------------
  logic [EW-1:0] bestErr;
  logic [1:0]    bestOrd;
  logic [EW-1:0] boundX;
  logic [1:0]    code_d;
  logic [EW-1:0] err_d;

  assign boundX = {4'b0000, s2Bound_q};

  // Strict less-than keeps the lower order on ties.
  always_comb begin
    bestErr = s2E0_q;
    bestOrd = 2'd0;
    if (s2E1_q < bestErr) begin
      bestErr = s2E1_q;
      bestOrd = 2'd1;
    end
    if (s2E2_q < bestErr) begin
      bestErr = s2E2_q;
      bestOrd = 2'd2;
    end
    if (bestErr <= boundX) begin
      code_d = bestOrd + 2'd1;
      err_d  = bestErr;
    end else begin
      code_d = 2'd0;
      err_d  = s2E0_q;
    end
  end

  logic               outValid_q;
  logic [1:0]         outCode_q;
  logic [WIDTH-1:0]   outData_q;
  logic [EW-1:0]      outErr_q;

  // ---------------------------------------------------------------------------
  // Pipeline registers. Every stage shares the advance enable so the pipe
  // moves as one; a bubble simply travels as valid = 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1P0_q     <= '0;
      s1P1_q     <= '0;
      s1P2_q     <= '0;
      s1Data_q   <= '0;
      s1Bound_q  <= '0;
      s2Valid_q  <= 1'b0;
      s2E0_q     <= '0;
      s2E1_q     <= '0;
      s2E2_q     <= '0;
      s2Data_q   <= '0;
      s2Bound_q  <= '0;
      outValid_q <= 1'b0;
      outCode_q  <= 2'd0;
      outData_q  <= '0;
      outErr_q   <= '0;
    end else if (advance) begin
      s1Valid_q  <= inXfer;
      s1P0_q     <= p0_d;
      s1P1_q     <= p1_d;
      s1P2_q     <= p2_d;
      s1Data_q   <= data;
      s1Bound_q  <= err_bound;
      s2Valid_q  <= s1Valid_q;
      s2E0_q     <= e0_d;
      s2E1_q     <= e1_d;
      s2E2_q     <= e2_d;
      s2Data_q   <= s1Data_q;
      s2Bound_q  <= s1Bound_q;
      outValid_q <= s2Valid_q;
      outCode_q  <= code_d;
      outData_q  <= s2Data_q;
      outErr_q   <= err_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_code  = outCode_q;
  assign out_data  = outData_q;
  assign out_err   = outErr_q;

  // ---------------------------------------------------------------------------
  // Unpredictable-point counter: counts code-0 results as they leave the
  // block, sticking at all-ones.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] unpredCnt_q;
  logic [CNT_W-1:0] unpredCnt_d;

  always_comb begin
    unpredCnt_d = unpredCnt_q;
    if (outXfer && (outCode_q == 2'd0) && (unpredCnt_q != {CNT_W{1'b1}})) begin
      unpredCnt_d = unpredCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unpredCnt_q <= '0;
    end else begin
      unpredCnt_q <= unpredCnt_d;
    end
  end

  assign unpred_count = unpredCnt_q;

endmodule

// File: tb/tb_curve_fit_predictor.sv
// -----------------------------------------------------------------------------
// tb_curve_fit_predictor
//
// Drives curve_fit_predictor with directed and randomized samples. A model
// computes each expected result with plain 64-bit arithmetic when a sample is
// accepted and queues it; a negedge monitor pops and compares every result as
// it leaves, checks stall stability, the ready rule and both counters. A
// second instance with CNT_W = 2 shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_curve_fit_predictor;

  localparam int W  = 32;
  localparam int EW = W + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inValid;
  logic [W-1:0]  inData;
  logic [W-1:0]  inQ1;
  logic [W-1:0]  inQ2;
  logic [W-1:0]  inQ3;
  logic [W-1:0]  inBound;
  logic          outReady;

  logic          inReady;
  logic          outValid;
  logic [1:0]    outCode;
  logic [W-1:0]  outData;
  logic [EW-1:0] outErr;
  logic [15:0]   unpredA;

  logic          bInReady;
  logic          bOutValid;
  logic [1:0]    bOutCode;
  logic [W-1:0]  bOutData;
  logic [EW-1:0] bOutErr;
  logic [1:0]    unpredB;

  always #5 clk = ~clk;

  curve_fit_predictor #(.WIDTH(W), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .data(inData), .q1(inQ1), .q2(inQ2), .q3(inQ3), .err_bound(inBound),
    .out_valid(outValid), .out_ready(outReady), .out_code(outCode),
    .out_data(outData), .out_err(outErr), .unpred_count(unpredA)
  );

  curve_fit_predictor #(.WIDTH(W), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(bInReady),
    .data(inData), .q1(inQ1), .q2(inQ2), .q3(inQ3), .err_bound(inBound),
    .out_valid(bOutValid), .out_ready(outReady), .out_code(bOutCode),
    .out_data(bOutData), .out_err(bOutErr), .unpred_count(unpredB)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    code;
    logic [EW-1:0] err;
    logic [W-1:0]  data;
  } res_t;

  function automatic res_t predict(input logic [W-1:0] a1, input logic [W-1:0] a2,
                                   input logic [W-1:0] a3, input logic [W-1:0] d,
                                   input logic [W-1:0] eb);
    res_t   r;
    longint v1, v2, v3, vd, bound;
    longint p [3];
    longint e [3];
    int     best;
    v1 = longint'($signed(a1));
    v2 = longint'($signed(a2));
    v3 = longint'($signed(a3));
    vd = longint'($signed(d));
    bound = longint'({32'b0, eb});
    p[0] = v3;
    p[1] = 2 * v3 - v2;
    p[2] = 3 * v3 - 3 * v2 + v1;
    for (int k = 0; k < 3; k++) begin
      e[k] = vd - p[k];
      if (e[k] < 0) e[k] = -e[k];
    end
    best = 0;
    for (int k = 1; k < 3; k++) if (e[k] < e[best]) best = k;
    if (e[best] <= bound) begin
      r.code = 2'(best + 1);
      r.err  = EW'(e[best]);
    end else begin
      r.code = 2'd0;
      r.err  = EW'(e[0]);
    end
    r.data = d;
    return r;
  endfunction

  res_t          expQ [$];
  int            cntA = 0;
  int            cntB = 0;
  bit            stalled = 0;
  logic [1:0]    prevCode;
  logic [W-1:0]  prevData;
  logic [EW-1:0] prevErr;

  // ---------------------------------------------------------------------------
  // Monitor: runs on every falling edge, looking at what the next rising
  // edge will do.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      expQ.delete();
      cntA = 0;
      cntB = 0;
      stalled = 0;
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady), 64'd0);
      checkOutput("rst_cnt_a", 64'(unpredA), 64'd0);
      checkOutput("rst_cnt_b", 64'(unpredB), 64'd0);
    end else begin
      checkOutput("in_ready_rule", 64'(inReady), 64'(!outValid || outReady));
      checkOutput("in_ready_rule_b", 64'(bInReady), 64'(!bOutValid || outReady));
      checkOutput("cnt_a", 64'(unpredA), 64'(cntA));
      checkOutput("cnt_b", 64'(unpredB), 64'(cntB));
      if (stalled) begin
        checkOutput("stall_valid", 64'(outValid), 64'd1);
        checkOutput("stall_code", 64'(outCode), 64'(prevCode));
        checkOutput("stall_data", 64'(outData), 64'(prevData));
        checkOutput("stall_err", 64'(outErr), 64'(prevErr));
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 64'(outValid), 64'd0);
        end else begin
          r = expQ.pop_front();
          checkOutput("out_code", 64'(outCode), 64'(r.code));
          checkOutput("out_data", 64'(outData), 64'(r.data));
          checkOutput("out_err", 64'(outErr), 64'(r.err));
          if (r.code == 2'd0) begin
            if (cntA < 65535) cntA++;
            if (cntB < 3) cntB++;
          end
        end
      end
      if (inValid && inReady) begin
        expQ.push_back(predict(inQ1, inQ2, inQ3, inData, inBound));
      end
      stalled  = outValid && !outReady;
      prevCode = outCode;
      prevData = outData;
      prevErr  = outErr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Callers are always at posedge+1.
  // ---------------------------------------------------------------------------
  task automatic applyStimulus(input bit v, input logic [W-1:0] a1, input logic [W-1:0] a2,
                               input logic [W-1:0] a3, input logic [W-1:0] d,
                               input logic [W-1:0] eb, input bit rdy, output bit xfer);
    inValid  = v;
    inQ1     = a1;
    inQ2     = a2;
    inQ3     = a3;
    inData   = d;
    inBound  = eb;
    outReady = rdy;
    #1;
    xfer = inValid && inReady;
    @(posedge clk);
    #1;
  endtask

  task automatic sendOne(input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] a3,
                         input logic [W-1:0] d, input logic [W-1:0] eb,
                         input logic [1:0] expCode, input logic [EW-1:0] expErr, input string tag);
    bit xfer;
    bit dummy;
    int n;
    n = 0;
    xfer = 0;
    while (!xfer && n < 10) begin
      applyStimulus(1'b1, a1, a2, a3, d, eb, 1'b1, xfer);
      n++;
    end
    checkOutput({tag, "_accept"}, 64'(xfer), 64'd1);
    n = 1;
    while (!outValid && n < 10) begin
      applyStimulus(1'b0, a1, a2, a3, d, eb, 1'b1, dummy);
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'd3);
    checkOutput({tag, "_code"}, 64'(outCode), 64'(expCode));
    checkOutput({tag, "_err"}, 64'(outErr), 64'(expErr));
    checkOutput({tag, "_data"}, 64'(outData), 64'(d));
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, dummy);
  endtask

  task automatic drain();
    bit dummy;
    repeat (6) applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, dummy);
    checkOutput("drained", 64'(expQ.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit   xfer;
    bit   seenDrop;
    int   idx;
    int   cyc;
    logic [W-1:0] base;
    logic [W-1:0] step;
    logic [W-1:0] r1, r2, r3, rd, rb;

    inValid = 0; inData = '0; inQ1 = '0; inQ2 = '0; inQ3 = '0; inBound = '0;
    outReady = 1;

    #1 rst = 1;
    #1;
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_out_code", 64'(outCode), 64'd0);
    checkOutput("reset_out_data", 64'(outData), 64'd0);
    checkOutput("reset_out_err", 64'(outErr), 64'd0);
    checkOutput("reset_unpred", 64'(unpredA), 64'd0);
    checkOutput("reset_in_ready", 64'(inReady), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Directed cases with hand-computed results
    sendOne(32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 2'd2, 36'd0, "ramp");
    sendOne(32'd1, 32'd4, 32'd9, 32'd16, 32'd0, 2'd3, 36'd0, "quad");
    sendOne(32'd1, 32'd4, 32'd9, 32'd18, 32'd2, 2'd3, 36'd2, "quad_eb");
    repeat (3) sendOne(32'd0, 32'd0, 32'd0, 32'd100, 32'd10, 2'd0, 36'd100, "unpred");
    checkOutput("unpred_a_3", 64'(unpredA), 64'd3);
    checkOutput("unpred_b_3", 64'(unpredB), 64'd3);
    repeat (2) sendOne(32'd0, 32'd0, 32'd0, 32'd100, 32'd10, 2'd0, 36'd100, "unpred");
    checkOutput("unpred_a_5", 64'(unpredA), 64'd5);
    checkOutput("unpred_b_sat", 64'(unpredB), 64'd3);
    sendOne(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF,
            2'd0, 36'h0FFFFFFFF, "ovf");
    checkOutput("unpred_a_6", 64'(unpredA), 64'd6);

    // Backpressure: six back-to-back samples, out_ready low for cycles 2..6
    idx = 0;
    cyc = 0;
    seenDrop = 0;
    while (idx < 6 && cyc < 40) begin
      applyStimulus(1'b1, W'(idx * 3), W'(idx * 3 + 1), W'(idx * 3 + 5), W'(idx * 7),
                    W'(idx), !(cyc >= 2 && cyc < 7), xfer);
      if (xfer) idx++;
      else seenDrop = 1;
      cyc++;
    end
    checkOutput("bp_in_ready_drop", 64'(seenDrop), 64'd1);
    checkOutput("bp_all_sent", 64'(idx), 64'd6);
    drain();

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      base = $urandom;
      step = W'($urandom_range(0, 200)) - W'(100);
      case ($urandom_range(0, 3))
        0: begin
          r1 = $urandom; r2 = $urandom; r3 = $urandom; rd = $urandom; rb = $urandom;
        end
        1: begin
          r1 = base; r2 = base + step; r3 = base + 2 * step;
          rd = base + 3 * step + W'($urandom_range(0, 4)) - W'(2);
          rb = W'($urandom_range(0, 3));
        end
        2: begin
          r1 = base; r2 = base + step; r3 = base + 4 * step;
          rd = base + 9 * step + W'($urandom_range(0, 2)) - W'(1);
          rb = W'($urandom_range(0, 2));
        end
        default: begin
          r1 = base; r2 = base; r3 = base;
          rd = base + W'($urandom_range(0, 40)) - W'(20);
          rb = W'($urandom_range(0, 25));
        end
      endcase
      applyStimulus($urandom_range(0, 3) != 0, r1, r2, r3, rd, rb,
                    $urandom_range(0, 3) != 0, xfer);
    end
    drain();

    // Reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, $urandom, $urandom, 32'd0, 1'b1, xfer);
    end
    inValid = 0;
    checkOutput("pre_reset_valid", 64'(outValid), 64'd1);
    checkOutput("pre_reset_cnt_nonzero", 64'(unpredA != 0), 64'd1);
    #2 rst = 1;
    #1;
    checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_cnt_a", 64'(unpredA), 64'd0);
    checkOutput("midrst_cnt_b", 64'(unpredB), 64'd0);
    checkOutput("midrst_in_ready", 64'(inReady), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, xfer);
      checkOutput("post_reset_no_stale", 64'(outValid), 64'd0);
    end
    sendOne(32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 2'd2, 36'd0, "post_rst_ramp");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
